// File: rtl/quadrature_pkg.sv
// ----------------------------------------------------------------------------
// quadrature_pkg
// Shared types and helpers for the rotary encoder quadrature decoder.
//   dec_state_t : decoder FSM states (seeding after reset, running)
//   Q00..Q01    : 2-bit {A,B} quadrature states
//   qstep_t     : classification of a (previous, current) state pair
//   quad_step() : classifies a state pair as none / cw / ccw / illegal
// ----------------------------------------------------------------------------
package quadrature_pkg;

  typedef enum logic {
    S_SEED = 1'b0,
    S_RUN  = 1'b1
  } dec_state_t;

  localparam logic [1:0] Q00 = 2'b00;
  localparam logic [1:0] Q10 = 2'b10;
  localparam logic [1:0] Q11 = 2'b11;
  localparam logic [1:0] Q01 = 2'b01;

  typedef enum logic [1:0] {
    QS_NONE    = 2'd0,
    QS_CW      = 2'd1,
    QS_CCW     = 2'd2,
    QS_ILLEGAL = 2'd3
  } qstep_t;

  // Position of a quadrature state on the clockwise ring 00->10->11->01.
  function automatic logic [1:0] quad_pos(input logic [1:0] q);
    logic [1:0] pos;
    case (q)
      Q00:     pos = 2'd0;
      Q10:     pos = 2'd1;
      Q11:     pos = 2'd2;
      default: pos = 2'd3;
    endcase
    return pos;
  endfunction

  // Ring distance (mod 4) decides the move: 1 forward is clockwise,
  // 3 forward is one step back, 2 means both phases flipped at once.
  function automatic qstep_t quad_step(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] diff;
    qstep_t     res;
    diff = quad_pos(cur) - quad_pos(prev);
    case (diff)
      2'd0:    res = QS_NONE;
      2'd1:    res = QS_CW;
      2'd3:    res = QS_CCW;
      default: res = QS_ILLEGAL;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/phase_filter.sv
// ----------------------------------------------------------------------------
// phase_filter
// Two-flop synchroniser followed by a stable-count glitch filter for one raw
// encoder phase. The filtered bit only follows the synchronised input after
// it has disagreed with the filtered bit for p_FILT_CYCLES consecutive cycles
// and still disagrees on the following cycle.
//
// Ports:
//   CLK     : system clock
//   RST     : asynchronous active-high reset
//   i_phase : raw phase pin, asynchronous to CLK
//   o_filt  : filtered phase level
// ----------------------------------------------------------------------------
module phase_filter #(
  parameter int unsigned p_FILT_CYCLES = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_phase,
  output logic o_filt
);

  localparam int unsigned CW = $clog2(p_FILT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_TC = CW'(p_FILT_CYCLES);

  logic          sync1;
  logic          sync2;
  logic          filt;
  logic [CW-1:0] stable_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= i_phase;
      sync2 <= sync1;
    end
  end

  // Any return to agreement before terminal count throws the run away.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      filt       <= 1'b0;
      stable_cnt <= '0;
    end else if (sync2 == filt) begin
      stable_cnt <= '0;
    end else if (stable_cnt == CNT_TC) begin
      filt       <= sync2;
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_cnt + 1'b1;
    end
  end

  assign o_filt = filt;

endmodule

// File: rtl/quadrature_decoder.sv
// ----------------------------------------------------------------------------
// quadrature_decoder
// Turns raw rotary encoder A/B pins into one-cycle detent step pulses with a
// direction flag, plus a one-cycle error pulse when both filtered phases
// change in the same cycle.
//
// Ports:
//   CLK       : system clock
//   RST       : asynchronous active-high reset
//   i_phase_a : raw encoder phase A (asynchronous)
//   i_phase_b : raw encoder phase B (asynchronous)
//   o_step    : one-cycle pulse per completed detent
//   o_cw      : direction of the current o_step, 1 = clockwise
//   o_err     : one-cycle pulse on an illegal (two-bit) transition
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_SEED | after reset: previous state tracks current, nothing counted
// S_RUN  | quarter-steps accumulated, steps and errors reported
// ----------------------------------------------------------------------------
module quadrature_decoder
  import quadrature_pkg::*;
#(
  parameter int unsigned p_FILT_CYCLES      = 16,
  parameter int unsigned p_STEPS_PER_DETENT = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_phase_a,
  input  logic i_phase_b,
  output logic o_step,
  output logic o_cw,
  output logic o_err
);

  localparam int unsigned AW = $clog2(p_STEPS_PER_DETENT) + 2;
  localparam int unsigned SW = $clog2(p_FILT_CYCLES + 4);

  // Seeding outlasts synchroniser plus filter latency, so a pin level
  // present at reset release settles into prev_q before S_RUN compares.
  localparam logic [SW-1:0]        SEED_LOAD = SW'(p_FILT_CYCLES + 3);
  localparam logic signed [AW-1:0] ACC_ONE   = AW'(1);
  localparam logic signed [AW-1:0] ACC_POS   = AW'(p_STEPS_PER_DETENT);
  localparam logic signed [AW-1:0] ACC_NEG   = -ACC_POS;

  logic                 filt_a;
  logic                 filt_b;
  logic [1:0]           cur_q;
  logic [1:0]           prev_q;
  logic [1:0]           prev_nxt;
  dec_state_t           state;
  dec_state_t           state_nxt;
  logic [SW-1:0]        seed_cnt;
  logic [SW-1:0]        seed_cnt_nxt;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_nxt;
  logic signed [AW-1:0] acc_inc;
  logic signed [AW-1:0] acc_dec;
  logic                 step_nxt;
  logic                 cw_nxt;
  logic                 err_nxt;
  qstep_t               qstep;

  phase_filter #(
    .p_FILT_CYCLES(p_FILT_CYCLES)
  ) u_filt_a (
    .CLK     (CLK),
    .RST     (RST),
    .i_phase (i_phase_a),
    .o_filt  (filt_a)
  );

  phase_filter #(
    .p_FILT_CYCLES(p_FILT_CYCLES)
  ) u_filt_b (
    .CLK     (CLK),
    .RST     (RST),
    .i_phase (i_phase_b),
    .o_filt  (filt_b)
  );

  assign cur_q   = {filt_a, filt_b};
  assign qstep   = quad_step(prev_q, cur_q);
  assign acc_inc = acc + ACC_ONE;
  assign acc_dec = acc - ACC_ONE;

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_SEED;
      seed_cnt <= SEED_LOAD;
    end else begin
      state    <= state_nxt;
      seed_cnt <= seed_cnt_nxt;
    end
  end

  // Next-state logic; the seed timer is a down-counter with terminal count 0
  always_comb begin
    state_nxt    = state;
    seed_cnt_nxt = seed_cnt;
    case (state)
      S_SEED: begin
        if (seed_cnt == '0) begin
          state_nxt = S_RUN;
        end else begin
          seed_cnt_nxt = seed_cnt - 1'b1;
        end
      end
      S_RUN:   state_nxt = S_RUN;
      default: state_nxt = S_SEED;
    endcase
  end

  // Output / datapath logic. prev_q follows cur_q every cycle in both states,
  // which also covers the "update previous state on error" case.
  always_comb begin
    prev_nxt = cur_q;
    acc_nxt  = acc;
    step_nxt = 1'b0;
    cw_nxt   = 1'b0;
    err_nxt  = 1'b0;
    if (state == S_RUN) begin
      case (qstep)
        QS_CW: begin
          if (acc_inc == ACC_POS) begin
            step_nxt = 1'b1;
            cw_nxt   = 1'b1;
            acc_nxt  = '0;
          end else begin
            acc_nxt = acc_inc;
          end
        end
        QS_CCW: begin
          if (acc_dec == ACC_NEG) begin
            step_nxt = 1'b1;
            acc_nxt  = '0;
          end else begin
            acc_nxt = acc_dec;
          end
        end
        QS_ILLEGAL: begin
          err_nxt = 1'b1;
          acc_nxt = '0;
        end
        default: acc_nxt = acc;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prev_q <= Q00;
      acc    <= '0;
      o_step <= 1'b0;
      o_cw   <= 1'b0;
      o_err  <= 1'b0;
    end else begin
      prev_q <= prev_nxt;
      acc    <= acc_nxt;
      o_step <= step_nxt;
      o_cw   <= cw_nxt;
      o_err  <= err_nxt;
    end
  end

endmodule

// File: doc/quadrature_decoder.md
# quadrature_decoder

Decodes the raw A/B phase pins of a mechanical rotary encoder into single-cycle detent step pulses with a direction flag and an error flag. Sits directly upstream of the top-level position counter: the counter increments or decrements by one on each `o_step`, according to `o_cw`. The block owns input synchronisation, per-phase glitch filtering, quadrature state tracking and detent accumulation, so raw PMOD pins connect to it directly.

## Interface
- `p_FILT_CYCLES`, 16: consecutive stable cycles required before a filtered phase changes; legal range 1..65535.
- `p_STEPS_PER_DETENT`, 4: quarter-steps per reported step; legal values 1, 2, 4.
- `CLK` input 1: system clock; all state updates on its rising edge.
- `RST` input 1: reset, asynchronous and active-high; clears all state.
- `i_phase_a` input 1: raw encoder phase A, asynchronous to `CLK`.
- `i_phase_b` input 1: raw encoder phase B, asynchronous to `CLK`.
- `o_step` output 1: one-cycle pulse, asserted once per completed detent.
- `o_cw` output 1: direction of the current `o_step`; 1 = clockwise. Valid only while `o_step` = 1.
- `o_err` output 1: one-cycle pulse on an illegal transition, i.e. both filtered phases changing in the same cycle.

## Operation
- **Sync:** each phase passes through a 2-flop synchroniser.
- **Filter:** each synchronised phase feeds its own filter, consisting of a stable counter and a filtered bit.
  - While the synced value equals the filtered bit, the counter is held at 0.
  - While they differ, the counter increments each cycle.
  - When the counter reaches `p_FILT_CYCLES`, the filtered bit takes the synced value and the counter clears.
  - A mismatch that returns to a match before that point clears the counter; no change propagates.
- **Quadrature state:** `{A,B}` of the filtered bits. The clockwise sequence is 00→10→11→01→00; counter-clockwise is the reverse. The state is compared each cycle with a registered previous state.
- **FSM:**
  - S_SEED is entered on reset. A seed counter runs for `p_FILT_CYCLES`+3 cycles after `RST` deasserts. During S_SEED, the previous state copies the current state each cycle, nothing is counted, and all outputs stay 0. On seed-counter expiry the FSM moves to S_RUN.
  - In S_RUN:
    - Unchanged state: no action.
    - Legal clockwise quarter-step: accumulator +1.
    - Legal counter-clockwise quarter-step: accumulator −1.
    - Both bits changed: `o_err` pulses, the accumulator clears to 0, the previous state is updated, and no step is issued.
- **Accumulator:** signed, width `$clog2(p_STEPS_PER_DETENT)`+2.
  - If the accumulator would reach +`p_STEPS_PER_DETENT`: `o_step`=1, `o_cw`=1, accumulator cleared to 0.
  - If it would reach −`p_STEPS_PER_DETENT`: `o_step`=1, `o_cw`=0, accumulator cleared to 0.
  - A direction reversal mid-detent counts back toward 0; partial motion never emits a step.
- **Simultaneous events:** the filters update at most one bit per phase per cycle. `o_step` and `o_err` are never asserted together.

## Timing
- **Reset values:** `o_step`=0, `o_cw`=0, `o_err`=0; synchronisers, filtered bits and previous state = 00; filter counters = 0; accumulator = 0; FSM = S_SEED.
- **Latency:** a phase edge that is stable from sampling edge t updates the filtered bit at t+2+`p_FILT_CYCLES`. A resulting `o_step` or `o_err` is registered and high during cycle t+3+`p_FILT_CYCLES` for exactly one cycle.
- **Throughput:** at most one quarter-step per cycle per phase. Pulses are never stretched or merged.
- **Reset mid-operation:** `RST` asserting clears everything asynchronously, and any pending partial detent is discarded. After release the block re-enters S_SEED. A non-00 pin state present at reset release is absorbed during seeding and produces neither a step nor an error.

## Structure
- **Package `quadrature_pkg`:** FSM state type {S_SEED, S_RUN}; the 2-bit quadrature state constants Q00, Q10, Q11, Q01; a function returning +1, −1, 0, or illegal for a (previous, current) state pair.
- **Sub-module `phase_filter`:** synchroniser plus stable-counter filter, parameterised by `p_FILT_CYCLES`, instantiated once per phase. The decoder FSM and accumulator live in `quadrature_decoder`.

## Test plan
- **Reset with pins at 11:** hold pins 11, release `RST`, idle 100 cycles → no `o_step`, no `o_err`; FSM in S_RUN.
- **Clockwise detent:** `p_FILT_CYCLES`=4, step 4. Drive 00→10→11→01→00, each level held 10 cycles → exactly one `o_step` with `o_cw`=1, occurring 7 cycles after the final edge.
- **Counter-clockwise, step 1:** `p_STEPS_PER_DETENT`=1. Drive 00→01→11 → two `o_step` pulses, both with `o_cw`=0.
- **Glitch rejection:** `p_FILT_CYCLES`=4. Pulse A high for 3 cycles → no filtered change, no outputs. Pulse A high for 6 cycles → filtered A changes.
- **Illegal jump and partial reversal:** drive 00→11 → one `o_err`, no step. Then drive 00→10→00 → accumulator back to 0, no step.
- **Reset mid-detent:** drive 2 clockwise quarter-steps, assert `RST`, release, then drive 2 more clockwise quarter-steps → no `o_step`.
